// File: rtl/lazy_summary_unit.sv
// Lazy-match arbitration stage: scores up to LAZY_MATCH_LEN candidates, picks
// the best-gain one and emits a single sequence plus the head-advance summary.
module lazy_summary_unit #(
    parameter int JOB_LEN         = 32,
    parameter int LAZY_MATCH_LEN  = 4,
    parameter int MATCH_LEN_WIDTH = 8,
    parameter int SEQ_LL_BITS     = 8,
    parameter int SEQ_ML_BITS     = 8,
    parameter int SEQ_OFFSET_BITS = 26,
    localparam int JOB_LEN_LOG2   = $clog2(JOB_LEN)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_match_done,
    input  logic [JOB_LEN_LOG2-1:0]                     i_match_head_ptr,
    input  logic [JOB_LEN_LOG2-1:0]                     i_seq_head_ptr,
    input  logic                                        i_delim,
    input  logic [LAZY_MATCH_LEN-1:0]                   i_match_valid,
    input  logic [LAZY_MATCH_LEN*MATCH_LEN_WIDTH-1:0]   i_match_len,
    input  logic [LAZY_MATCH_LEN*SEQ_OFFSET_BITS-1:0]   i_offset,
    output logic                                        o_summary_done,
    output logic [JOB_LEN_LOG2-1:0]                     o_seq_head_ptr,
    output logic [SEQ_LL_BITS-1:0]                      o_summary_ll,
    output logic [SEQ_ML_BITS-1:0]                      o_summary_ml,
    output logic [SEQ_OFFSET_BITS-1:0]                  o_summary_offset,
    output logic                                        o_summary_eoj,
    output logic [SEQ_ML_BITS-1:0]                      o_summary_overlap_len,
    output logic                                        o_summary_delim,
    output logic                                        o_move_to_next_job,
    output logic [JOB_LEN_LOG2-1:0]                     o_move_forward
);

    localparam int GW = MATCH_LEN_WIDTH + 3;
    localparam int KW = (LAZY_MATCH_LEN > 1) ? $clog2(LAZY_MATCH_LEN) : 1;
    localparam int EW = ((MATCH_LEN_WIDTH > JOB_LEN_LOG2) ? MATCH_LEN_WIDTH : JOB_LEN_LOG2) + 2;

    function automatic logic [GW-1:0] highbit(input logic [SEQ_OFFSET_BITS-1:0] x);
        highbit = '0;
        for (int unsigned b = 0; b < SEQ_OFFSET_BITS; b++)
            if (x[b]) highbit = GW'(b);
    endfunction

    // ---------------- S1: inputs and gains ----------------
    logic signed [GW-1:0] gain_c [LAZY_MATCH_LEN];

    always_comb begin
        for (int unsigned i = 0; i < LAZY_MATCH_LEN; i++) begin
            gain_c[i] = $signed({1'b0, i_match_len[i*MATCH_LEN_WIDTH +: MATCH_LEN_WIDTH], 2'b00})
                      - $signed(highbit(i_offset[i*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS]))
                      - $signed(GW'(4 * i));
        end
    end

    logic                                      s1_valid;
    logic [JOB_LEN_LOG2-1:0]                   s1_mh, s1_sh;
    logic                                      s1_delim;
    logic [LAZY_MATCH_LEN-1:0]                 s1_mvalid;
    logic [LAZY_MATCH_LEN*MATCH_LEN_WIDTH-1:0] s1_len;
    logic [LAZY_MATCH_LEN*SEQ_OFFSET_BITS-1:0] s1_off;
    logic signed [GW-1:0]                      s1_gain [LAZY_MATCH_LEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_mh     <= '0;
            s1_sh     <= '0;
            s1_delim  <= 1'b0;
            s1_mvalid <= '0;
            s1_len    <= '0;
            s1_off    <= '0;
            for (int unsigned i = 0; i < LAZY_MATCH_LEN; i++) s1_gain[i] <= '0;
        end else begin
            s1_valid  <= i_match_done;
            s1_mh     <= i_match_head_ptr;
            s1_sh     <= i_seq_head_ptr;
            s1_delim  <= i_delim;
            s1_mvalid <= i_match_valid;
            s1_len    <= i_match_len;
            s1_off    <= i_offset;
            for (int unsigned i = 0; i < LAZY_MATCH_LEN; i++) s1_gain[i] <= gain_c[i];
        end
    end

    // ---------------- S2: selection ----------------
    logic [LAZY_MATCH_LEN-1:0]  is_max, sel_oh;
    logic [KW-1:0]              k_c;
    logic [MATCH_LEN_WIDTH-1:0] len_c;
    logic [SEQ_OFFSET_BITS-1:0] off_c;

    always_comb begin
        is_max = s1_mvalid;
        for (int unsigned i = 0; i < LAZY_MATCH_LEN; i++)
            for (int unsigned j = 0; j < LAZY_MATCH_LEN; j++)
                if (s1_mvalid[j] && (s1_gain[j] > s1_gain[i])) is_max[i] = 1'b0;
        // Lowest set bit wins ties; an empty vector falls back to candidate 0.
        sel_oh = is_max & (~is_max + 1'b1);
        if (sel_oh == '0) sel_oh = LAZY_MATCH_LEN'(1);
        k_c   = '0;
        len_c = '0;
        off_c = '0;
        for (int unsigned i = 0; i < LAZY_MATCH_LEN; i++) begin
            if (sel_oh[i]) k_c = KW'(i);
            len_c = len_c | (s1_len[i*MATCH_LEN_WIDTH +: MATCH_LEN_WIDTH] & {MATCH_LEN_WIDTH{sel_oh[i]}});
            off_c = off_c | (s1_off[i*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS] & {SEQ_OFFSET_BITS{sel_oh[i]}});
        end
    end

    logic                       s2_valid;
    logic [JOB_LEN_LOG2-1:0]    s2_mh, s2_sh;
    logic                       s2_delim;
    logic [KW-1:0]              s2_k;
    logic [MATCH_LEN_WIDTH-1:0] s2_len;
    logic [SEQ_OFFSET_BITS-1:0] s2_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mh    <= '0;
            s2_sh    <= '0;
            s2_delim <= 1'b0;
            s2_k     <= '0;
            s2_len   <= '0;
            s2_off   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_mh    <= s1_mh;
            s2_sh    <= s1_sh;
            s2_delim <= s1_delim;
            s2_k     <= k_c;
            s2_len   <= len_c;
            s2_off   <= off_c;
        end
    end

    // ---------------- S3: sequence and head advance ----------------
    logic [EW-1:0]           p_c, e_c;
    logic                    eoj_c;
    logic [JOB_LEN_LOG2-1:0] ll_c, mf_c;

    always_comb begin
        p_c   = EW'(s2_mh) + EW'(s2_k);
        e_c   = p_c + EW'(s2_len);
        eoj_c = (e_c >= EW'(JOB_LEN));
        ll_c  = p_c[JOB_LEN_LOG2-1:0] - s2_sh;
        mf_c  = e_c[JOB_LEN_LOG2-1:0] - s2_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_summary_done        <= 1'b0;
            o_seq_head_ptr        <= '0;
            o_summary_ll          <= '0;
            o_summary_ml          <= '0;
            o_summary_offset      <= '0;
            o_summary_eoj         <= 1'b0;
            o_summary_overlap_len <= '0;
            o_summary_delim       <= 1'b0;
            o_move_to_next_job    <= 1'b0;
            o_move_forward        <= '0;
        end else begin
            o_summary_done        <= s2_valid;
            o_seq_head_ptr        <= s2_sh;
            o_summary_ll          <= SEQ_LL_BITS'(ll_c);
            o_summary_ml          <= SEQ_ML_BITS'(s2_len);
            o_summary_offset      <= s2_off;
            o_summary_eoj         <= eoj_c;
            o_summary_overlap_len <= eoj_c ? SEQ_ML_BITS'(e_c - EW'(JOB_LEN)) : '0;
            o_summary_delim       <= eoj_c & s2_delim;
            o_move_to_next_job    <= eoj_c;
            o_move_forward        <= eoj_c ? '0 : mf_c;
        end
    end

endmodule

// File: tb/tb_lazy_summary_unit.sv
// Directed bench for lazy_summary_unit: vector table plus reset and pulse-width sequences.
module tb_lazy_summary_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_match_done;
    logic [4:0]   i_match_head_ptr, i_seq_head_ptr;
    logic         i_delim;
    logic [3:0]   i_match_valid;
    logic [31:0]  i_match_len;
    logic [103:0] i_offset;
    logic         o_summary_done;
    logic [4:0]   o_seq_head_ptr;
    logic [7:0]   o_summary_ll, o_summary_ml, o_summary_overlap_len;
    logic [25:0]  o_summary_offset;
    logic         o_summary_eoj, o_summary_delim, o_move_to_next_job;
    logic [4:0]   o_move_forward;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lazy_summary_unit #(
        .JOB_LEN(32), .LAZY_MATCH_LEN(4), .MATCH_LEN_WIDTH(8),
        .SEQ_LL_BITS(8), .SEQ_ML_BITS(8), .SEQ_OFFSET_BITS(26)
    ) dut (
        .clk(clk), .rst(rst), .i_match_done(i_match_done),
        .i_match_head_ptr(i_match_head_ptr), .i_seq_head_ptr(i_seq_head_ptr),
        .i_delim(i_delim), .i_match_valid(i_match_valid), .i_match_len(i_match_len),
        .i_offset(i_offset), .o_summary_done(o_summary_done), .o_seq_head_ptr(o_seq_head_ptr),
        .o_summary_ll(o_summary_ll), .o_summary_ml(o_summary_ml),
        .o_summary_offset(o_summary_offset), .o_summary_eoj(o_summary_eoj),
        .o_summary_overlap_len(o_summary_overlap_len), .o_summary_delim(o_summary_delim),
        .o_move_to_next_job(o_move_to_next_job), .o_move_forward(o_move_forward)
    );

    typedef struct {
        string        name;
        logic [3:0]   valid;
        logic [31:0]  len;
        logic [103:0] off;
        logic [4:0]   mh, sh;
        logic         delim;
        logic [7:0]   e_ll, e_ml;
        logic [25:0]  e_off;
        logic         e_eoj;
        logic [7:0]   e_ovl;
        logic         e_delim, e_next;
        logic [4:0]   e_mf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, 64'(o_summary_done), 64'd0);
        check({tag, "_sph"},  64'(o_seq_head_ptr), 64'd0);
        check({tag, "_ll"},   64'(o_summary_ll), 64'd0);
        check({tag, "_ml"},   64'(o_summary_ml), 64'd0);
        check({tag, "_off"},  64'(o_summary_offset), 64'd0);
        check({tag, "_eoj"},  64'(o_summary_eoj), 64'd0);
        check({tag, "_ovl"},  64'(o_summary_overlap_len), 64'd0);
        check({tag, "_dlm"},  64'(o_summary_delim), 64'd0);
        check({tag, "_next"}, 64'(o_move_to_next_job), 64'd0);
        check({tag, "_mf"},   64'(o_move_forward), 64'd0);
    endtask

    task automatic drive(input vec_t v);
        i_match_valid    = v.valid;
        i_match_len      = v.len;
        i_offset         = v.off;
        i_match_head_ptr = v.mh;
        i_seq_head_ptr   = v.sh;
        i_delim          = v.delim;
    endtask

    initial begin
        //              name     valid    len {L3,L2,L1,L0}              offset {O3,O2,O1,O0}                               mh     sh     dlm  ll    ml     off          eoj  ovl  dlm  nxt  mf
        vecs[0] = '{"single", 4'b0001, {8'd0,8'd0,8'd0,8'd10},   {26'd0,26'd0,26'd0,26'd100},             5'd5,  5'd2,  1'b0, 8'd3, 8'd10, 26'd100,     1'b0, 8'd0, 1'b0, 1'b0, 5'd13};
        vecs[1] = '{"lazy",   4'b0011, {8'd0,8'd0,8'd8,8'd5},    {26'd0,26'd0,26'd8,26'd8},               5'd4,  5'd4,  1'b0, 8'd1, 8'd8,  26'd8,       1'b0, 8'd0, 1'b0, 1'b0, 5'd9};
        vecs[2] = '{"tie",    4'b0011, {8'd0,8'd0,8'd6,8'd5},    {26'd0,26'd0,26'd16,26'd16},             5'd7,  5'd7,  1'b0, 8'd0, 8'd5,  26'd16,      1'b0, 8'd0, 1'b0, 1'b0, 5'd5};
        vecs[3] = '{"past",   4'b0001, {8'd0,8'd0,8'd0,8'd10},   {26'd0,26'd0,26'd0,26'd1},               5'd28, 5'd20, 1'b1, 8'd8, 8'd10, 26'd1,       1'b1, 8'd6, 1'b1, 1'b1, 5'd0};
        vecs[4] = '{"exact",  4'b0001, {8'd0,8'd0,8'd0,8'd4},    {26'd0,26'd0,26'd0,26'd1},               5'd28, 5'd20, 1'b0, 8'd8, 8'd4,  26'd1,       1'b1, 8'd0, 1'b0, 1'b1, 5'd0};
        vecs[5] = '{"below",  4'b0001, {8'd0,8'd0,8'd0,8'd3},    {26'd0,26'd0,26'd0,26'd1},               5'd28, 5'd20, 1'b1, 8'd8, 8'd3,  26'd1,       1'b0, 8'd0, 1'b0, 1'b0, 5'd11};
        vecs[6] = '{"invsk",  4'b0101, {8'd60,8'd9,8'd50,8'd4},  {26'd0,26'd4,26'd0,26'd2},               5'd0,  5'd0,  1'b0, 8'd2, 8'd9,  26'd4,       1'b0, 8'd0, 1'b0, 1'b0, 5'd11};
        vecs[7] = '{"cand3",  4'b1111, {8'd20,8'd1,8'd1,8'd1},   {26'd33554432,26'd1,26'd1,26'd1},        5'd10, 5'd3,  1'b1, 8'd10,8'd20, 26'd33554432,1'b1, 8'd1, 1'b1, 1'b1, 5'd0};
        vecs[8] = '{"neg",    4'b0011, {8'd0,8'd0,8'd2,8'd1},    {26'd0,26'd0,26'd1,26'd33554431},        5'd3,  5'd1,  1'b0, 8'd3, 8'd2,  26'd1,       1'b0, 8'd0, 1'b0, 1'b0, 5'd5};

        rst = 1'b1;
        i_match_done = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst0");
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            drive(vecs[v]);
            i_match_done = 1'b1;
            repeat (2) @(posedge clk);
            #1 check({vecs[v].name, "_early"}, 64'(o_summary_done), 64'd0);
            @(posedge clk);
            #1;
            check({vecs[v].name, "_done"}, 64'(o_summary_done), 64'd1);
            check({vecs[v].name, "_sph"},  64'(o_seq_head_ptr), 64'(vecs[v].sh));
            check({vecs[v].name, "_ll"},   64'(o_summary_ll), 64'(vecs[v].e_ll));
            check({vecs[v].name, "_ml"},   64'(o_summary_ml), 64'(vecs[v].e_ml));
            check({vecs[v].name, "_off"},  64'(o_summary_offset), 64'(vecs[v].e_off));
            check({vecs[v].name, "_eoj"},  64'(o_summary_eoj), 64'(vecs[v].e_eoj));
            check({vecs[v].name, "_ovl"},  64'(o_summary_overlap_len), 64'(vecs[v].e_ovl));
            check({vecs[v].name, "_dlm"},  64'(o_summary_delim), 64'(vecs[v].e_delim));
            check({vecs[v].name, "_next"}, 64'(o_move_to_next_job), 64'(vecs[v].e_next));
            check({vecs[v].name, "_mf"},   64'(o_move_forward), 64'(vecs[v].e_mf));
            i_match_done = 1'b0;
            repeat (2) @(posedge clk);
            #1 check({vecs[v].name, "_hold"}, 64'(o_summary_done), 64'd1);
            @(posedge clk);
            #1 check({vecs[v].name, "_fall"}, 64'(o_summary_done), 64'd0);
        end

        // Reset one cycle into a transaction: outputs clear and nothing emerges.
        begin
            int cnt;
            drive(vecs[0]);
            i_match_done = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b1;
            i_match_done = 1'b0;
            @(posedge clk);
            #1;
            check_all_zero("midrst");
            rst = 1'b0;
            cnt = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1 if (o_summary_done) cnt++;
            end
            check("midrst_pulses", 64'(cnt), 64'd0);
        end

        // Two-cycle done in gives a two-cycle done out, starting three cycles later.
        begin
            int cnt, first;
            drive(vecs[1]);
            i_match_done = 1'b1;
            cnt = 0;
            first = 0;
            for (int c = 1; c <= 8; c++) begin
                @(posedge clk);
                #1;
                if (o_summary_done) begin
                    cnt++;
                    if (first == 0) first = c;
                end
                if (c == 2) i_match_done = 1'b0;
            end
            check("pulse_len", 64'(cnt), 64'd2);
            check("pulse_start", 64'(first), 64'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
